// File: rtl/i2osp_serializer.sv
// i2osp_serializer: streams an unsigned integer as a big-endian octet string of x_len octets.
// Ports: clk, reset_n (async active-low); start/in_value/x_len form the request;
//        out_octet/out_valid/out_ready/last_octet form the output stream;
//        busy (not IDLE), done (pulse after the final transfer), error (pulse on a rejected request).
// Optional macro I2OSP_RANGE_CHECK_EN: also reject requests whose in_value >= 256^x_len.
module i2osp_serializer #(
    parameter int DATA_BIT_WIDTH = 2048,
    localparam int NUM_OCTETS = DATA_BIT_WIDTH / 8,
    localparam int LEN_W = $clog2(NUM_OCTETS + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [DATA_BIT_WIDTH-1:0] in_value,
    input  logic [LEN_W-1:0]          x_len,
    output logic [7:0]                out_octet,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      last_octet,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    typedef enum logic [1:0] {IDLE, SEND, ERR} state_t;
    state_t state_q, state_d;
    logic [DATA_BIT_WIDTH-1:0] data_q;
    logic [LEN_W-1:0] cnt_q, pad;
    logic done_q, too_big, reject, accept, fire, last;
`ifdef I2OSP_RANGE_CHECK_EN
    assign too_big = |(in_value >> {x_len, 3'b000});
`else
    assign too_big = 1'b0;
`endif
    assign reject = x_len == '0 || x_len > LEN_W'(NUM_OCTETS) || too_big;
    assign accept = state_q == IDLE && start && !reject;
    assign fire = out_valid && out_ready;
    assign last = cnt_q == LEN_W'(1);
    // Left-align the requested octets so the current octet is always the top byte;
    // octets above x_len fall off the top and are dropped.
    assign pad = LEN_W'(NUM_OCTETS) - x_len;
    assign out_valid = state_q == SEND;
    assign out_octet = out_valid ? data_q[DATA_BIT_WIDTH-1 -: 8] : 8'h00;
    assign last_octet = out_valid && last;
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign error = state_q == ERR;
    always_comb begin
        state_d = state_q;
        state_d = state_q == IDLE ? (start ? (reject ? ERR : SEND) : IDLE)
                : state_q == SEND ? ((fire && last) ? IDLE : SEND)
                : IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q <= '0;
            cnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q <= fire && last;
            if (accept) begin
                data_q <= in_value << {pad, 3'b000};
                cnt_q <= x_len;
            end else if (fire) begin
                data_q <= data_q << 8;
                cnt_q <= cnt_q - LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_i2osp_serializer.sv
// tb_i2osp_serializer: directed self-checking bench for i2osp_serializer at the default 2048-bit width.
module tb_i2osp_serializer;
    logic clk, reset_n, start, out_ready;
    logic [2047:0] in_value;
    logic [8:0] x_len;
    logic [7:0] out_octet;
    logic out_valid, last_octet, busy, done, error;
    int checks = 0;
    int errors = 0;

    i2osp_serializer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_value(in_value), .x_len(x_len),
        .out_octet(out_octet), .out_valid(out_valid), .out_ready(out_ready),
        .last_octet(last_octet), .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic kick(input logic [2047:0] v, input logic [8:0] len);
        @(negedge clk);
        in_value = v;
        x_len = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; out_ready = 1'b0; in_value = '0; x_len = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_octet, out_valid, last_octet, busy, done, error} !== 13'h0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0000", {out_octet, out_valid, last_octet, busy, done, error});
        end
        reset_n = 1'b1;
        in_value = 2048'h77;
        x_len = 9'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_octet !== 8'h77 || last_octet !== 1'b1) begin
            errors++;
            $display("FAIL first_start: got v=%b o=%h l=%b expected v=1 o=77 l=1", out_valid, out_octet, last_octet);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_done: got done=%b v=%b expected done=1 v=0", done, out_valid);
        end
    endtask

    task automatic test_full;
        logic [2047:0] v;
        for (int j = 0; j < 256; j++) v[8*j +: 8] = 8'(256 - j);
        out_ready = 1'b1;
        kick(v, 9'd256);
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_octet !== 8'(i + 1) || last_octet !== 1'(i == 255)) begin
                errors++;
                $display("FAIL full_octet[%0d]: got v=%b o=%h l=%b expected v=1 o=%h l=%b",
                         i, out_valid, out_octet, last_octet, 8'(i + 1), 1'(i == 255));
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_done: got done=%b v=%b busy=%b expected 1 0 0", done, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL full_done_pulse: got done=%b expected 0", done);
        end
    endtask

    task automatic test_stall;
        logic [7:0] exp_o [4];
        int idx;
        exp_o = '{8'h00, 8'h00, 8'hAB, 8'hCD};
        idx = 0;
        out_ready = 1'b0;
        kick(2048'hABCD, 9'd4);
        for (int c = 0; c < 20 && idx < 4; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_octet !== exp_o[idx] || last_octet !== 1'(idx == 3)) begin
                errors++;
                $display("FAIL stall_octet[%0d]: got v=%b o=%h l=%b expected v=1 o=%h l=%b",
                         idx, out_valid, out_octet, last_octet, exp_o[idx], 1'(idx == 3));
            end
            out_ready = (c % 2) == 1;
            if (out_ready) idx++;
            @(negedge clk);
        end
        checks++;
        if (idx != 4) begin
            errors++;
            $display("FAIL stall_timeout: got %0d octets expected 4", idx);
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: got done=%b v=%b expected 1 0", done, out_valid);
        end
    endtask

    task automatic test_errors;
        logic [8:0] lens [2];
        lens = '{9'd0, 9'd257};
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            kick(2048'h1234, lens[k]);
            checks++;
            if (error !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL err_pulse[len=%0d]: got e=%b b=%b v=%b d=%b expected 1 1 0 0",
                         lens[k], error, busy, out_valid, done);
            end
            @(negedge clk);
            checks++;
            if (error !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL err_end[len=%0d]: got e=%b b=%b v=%b expected 0 0 0", lens[k], error, busy, out_valid);
            end
        end
    endtask

    task automatic test_range;
        out_ready = 1'b1;
        kick(2048'h10000, 9'd2);
`ifdef I2OSP_RANGE_CHECK_EN
        checks++;
        if (error !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL range_reject: got e=%b v=%b expected 1 0", error, out_valid);
        end
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL range_end: got e=%b v=%b b=%b expected 0 0 0", error, out_valid, busy);
        end
`else
        checks++;
        if (out_valid !== 1'b1 || out_octet !== 8'h00 || last_octet !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL range_drop0: got v=%b o=%h l=%b e=%b expected 1 00 0 0", out_valid, out_octet, last_octet, error);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_octet !== 8'h00 || last_octet !== 1'b1) begin
            errors++;
            $display("FAIL range_drop1: got v=%b o=%h l=%b expected 1 00 1", out_valid, out_octet, last_octet);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL range_done: got done=%b v=%b expected 1 0", done, out_valid);
        end
`endif
    endtask

    task automatic test_reset_mid;
        logic [2047:0] v;
        v = '0;
        for (int j = 0; j < 16; j++) v[8*j +: 8] = 8'(8'h1F - j);
        out_ready = 1'b1;
        kick(v, 9'd16);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_octet !== 8'(8'h10 + i)) begin
                errors++;
                $display("FAIL mid_octet[%0d]: got v=%b o=%h expected v=1 o=%h", i, out_valid, out_octet, 8'(8'h10 + i));
            end
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_octet, out_valid, last_octet, busy, done, error} !== 13'h0) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 0000", {out_octet, out_valid, last_octet, busy, done, error});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_after[%0d]: got v=%b d=%b b=%b expected 0 0 0", i, out_valid, done, busy);
            end
        end
        kick(2048'h3C, 9'd1);
        checks++;
        if (out_valid !== 1'b1 || out_octet !== 8'h3C || last_octet !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart: got v=%b o=%h l=%b expected 1 3c 1", out_valid, out_octet, last_octet);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        @(negedge clk);
        in_value = 2048'h5A;
        x_len = 9'd1;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_octet !== 8'h5A || last_octet !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got v=%b o=%h l=%b expected 1 5a 1", out_valid, out_octet, last_octet);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got d=%b v=%b b=%b expected 1 0 0", done, out_valid, busy);
        end
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_octet !== 8'h5A || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got v=%b o=%h d=%b expected 1 5a 0", out_valid, out_octet, done);
        end
        in_value = 2048'hC3;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_octet !== 8'h5A || last_octet !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: got v=%b o=%h l=%b expected 1 5a 1", out_valid, out_octet, last_octet);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: got d=%b v=%b expected 1 0", done, out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got d=%b b=%b expected 0 0", done, busy);
        end
    endtask

    initial begin
        test_reset;
        test_full;
        test_stall;
        test_errors;
        test_range;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2osp_serializer.md
I2OSP_SERIALIZER -- requirements
Module: i2osp_serializer

Interface
REQ-001 Parameter DATA_BIT_WIDTH, default 2048, is the integer width in bits; it SHALL be a multiple of 8.
REQ-002 Localparams SHALL be NUM_OCTETS = DATA_BIT_WIDTH/8 and LEN_W = $clog2(NUM_OCTETS+1), which is 9 at default.
REQ-003 Port clk  input  1  is the single clock; all logic SHALL be rising-edge.
REQ-004 Port reset_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port start  input  1  requests conversion of in_value.
REQ-006 Port in_value  input  DATA_BIT_WIDTH  is the unsigned integer to convert.
REQ-007 Port x_len  input  LEN_W  is the requested output length in octets.
REQ-008 Port out_octet  output  8  is the current octet, most significant first.
REQ-009 Port out_valid  output  1  indicates out_octet is valid.
REQ-010 Port out_ready  input  1  is the downstream accept signal.
REQ-011 Port last_octet  output  1  marks the final octet of the string.
REQ-012 Port busy  output  1  is high while not IDLE.
REQ-013 Port done  output  1  is a one-cycle pulse after the final octet transfers.
REQ-014 Port error  output  1  is a one-cycle pulse when a request is rejected.

Function
REQ-015 The block SHALL have exactly three states: IDLE, SEND and ERR.
REQ-016 In IDLE, start=1 SHALL capture in_value and x_len on that edge; start is ignored in every other state.
REQ-017 A request with x_len=0 or x_len>NUM_OCTETS SHALL enter ERR; otherwise it SHALL enter SEND.
REQ-018 out_valid SHALL rise on the cycle after start is accepted, giving a latency of 1 cycle to the first octet.
REQ-019 The octets emitted SHALL be in_value[8*(x_len-1)+:8] first, down to in_value[7:0] last, for exactly x_len octets.
REQ-020 A transfer SHALL occur only when out_valid and out_ready are both 1 on a rising edge.
REQ-021 out_octet and last_octet SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 last_octet SHALL be 1 only while out_valid=1 and the last octet is presented.
REQ-023 After the last transfer, the block SHALL go to IDLE, and done SHALL be 1 for exactly the following cycle.
REQ-024 A new start SHALL be accepted in the cycle done is high, so back-to-back strings have 1 idle cycle between them.
REQ-025 ERR SHALL last one cycle with error=1 and out_valid=0, then return to IDLE.
REQ-026 busy SHALL be 1 in SEND and ERR and 0 in IDLE.
REQ-027 out_ready SHALL have no effect while out_valid=0.
REQ-028 An octet counter SHALL count down from x_len to 1 with no wrap-around; x_len=1 emits a single octet with last_octet=1.

Reset
REQ-029 While reset_n=0, the state SHALL be IDLE and out_octet=8'h00, out_valid=0, last_octet=0, busy=0, done=0, error=0; internal registers SHALL be cleared.
REQ-030 Reset asserted mid-SEND SHALL abort the string immediately, with no done and no further octets after release.
REQ-031 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-032 Macro I2OSP_RANGE_CHECK_EN, when defined, SHALL reject any in_value >= 256^x_len: the block enters ERR, pulses error, and emits no octets.
REQ-033 Without I2OSP_RANGE_CHECK_EN, octets of in_value above x_len SHALL be silently dropped, and only the range check in REQ-017 SHALL apply.

Verification
REQ-034 Scenario: in_value=0x0102...0100 (2048 bits), x_len=256, out_ready=1 -> 256 octets 01,02,...,FF,00 on consecutive cycles, last_octet on octet 256, done 1 cycle later.
REQ-035 Scenario: in_value=0xABCD, x_len=4, out_ready toggling 1/0 -> octets 00,00,AB,CD, each held stable while stalled, last_octet with CD.
REQ-036 Scenario: x_len=0, then x_len=257 -> one error pulse each, out_valid stays 0, busy=1 for one cycle.
REQ-037 Scenario: in_value=0x1_0000, x_len=2 -> with I2OSP_RANGE_CHECK_EN: error pulse, no output; without it: octets 00,00.
REQ-038 Scenario: reset_n pulsed low after the 3rd transfer of a 16-octet string -> outputs are at reset values immediately, no done, and IDLE accepts a new start afterwards.
REQ-039 Scenario: start held high across completion with x_len=1, in_value=0x5A -> strings 5A,5A separated by one done cycle, and start is ignored during SEND.
